// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding and the default frame timing used by the
// receiver, the transmitter and their benches.
package uart_pkg;

  // 12.5 MHz system clock at 9600 baud.
  localparam int DEF_CLKS_PER_BIT = 1302;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte stream carrying received bytes from the UART receiver to its consumer.
//   m_data  : received byte, stable while m_valid is high
//   m_valid : a byte is held and available
//   m_ready : consumer takes the byte when m_valid && m_ready
// master = byte producer (receiver), slave = byte consumer.
interface uart_rx_byte_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both flops load RESET_VAL
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i cycles of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver front end with a one-entry valid/ready holding register.
//   sysclk      : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   uart_txd_in : serial line, idle high, asynchronous to sysclk
//   m           : received byte stream (master side)
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun     : one-cycle pulse, byte completed while the holding register
//                 was full and not draining; that byte is dropped
//   busy        : receiver is not idle
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic           sysclk,
  input  logic           rst_n,
  input  logic           uart_txd_in,
  uart_rx_byte_if.master m,
  output logic           frame_err,
  output logic           overrun,
  output logic           busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 load_pend_q, load_pend_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;

  // Idle-high line, so the synchronizer resets to 1 and a reset alone
  // never looks like a start bit.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk_i  (sysclk),
    .rst_ni (rst_n),
    .d_i    (uart_txd_in),
    .q_o    (rxs)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      load_pend_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      load_pend_q <= load_pend_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    load_pend_d = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      // Re-check the start bit half a bit later; a short glitch is dropped.
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxs ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      // Shifting in from the top leaves the first (LSB) bit at bit 0.
      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rxs) begin
            load_pend_d = 1'b1;
            state_d     = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      // A stuck-low line must return high before another start is accepted.
      WAIT_HIGH: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Holding register: a drain and a load in the same cycle keep m_valid
    // set with the new byte; a load into a full, stalled register is dropped.
    if (m_valid_q && m.m_ready) begin
      m_valid_d = 1'b0;
    end
    if (load_pend_q) begin
      if (!m_valid_q || m.m_ready) begin
        m_data_d  = shift_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign m.m_data  = m_data_q;
  assign m.m_valid = m_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte. Frames are driven bit by bit on the serial line;
// a frame-level model pushes the expected bytes and error pulses, and a
// monitor pops and compares every byte the DUT hands over.
module tb_uart_rx_byte;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic uart_txd_in = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_rx_byte_if #(.DATA_BITS(DB)) bus ();

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .uart_txd_in (uart_txd_in),
    .m           (bus.master),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 sysclk = ~sysclk;

  int nVectors = 0;
  int nMis = 0;
  int cyc = 0;
  int startCyc = 0;
  int nFrameErr = 0;
  int nOverrun = 0;
  int expFrameErr = 0;
  int expOverrun = 0;
  logic [DB-1:0] expQ[$];
  logic prevHold = 1'b0;
  logic [DB-1:0] prevData = '0;

  always @(posedge sysclk) cyc <= cyc + 1;

  // One comparison: counts it and reports a miscompare on its own line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sysclk);
  endtask

  // Drives one frame starting 1 ns after the current posedge; a low stop bit
  // is followed by one bit time of high line.
  task automatic sendFrame(input logic [DB-1:0] data, input logic stopBit);
    #1 uart_txd_in = 1'b0;
    startCyc = cyc;
    repeat (CPB) @(posedge sysclk);
    for (int i = 0; i < DB; i++) begin
      #1 uart_txd_in = data[i];
      repeat (CPB) @(posedge sysclk);
    end
    #1 uart_txd_in = stopBit;
    repeat (CPB) @(posedge sysclk);
    if (!stopBit) begin
      #1 uart_txd_in = 1'b1;
      repeat (CPB) @(posedge sysclk);
    end
  endtask

  // Frame-level model: a bad stop bit is a framing error; a good frame is
  // delivered unless a byte is already waiting on a stalled consumer.
  task automatic applyStimulus(input logic [DB-1:0] data, input logic stopBit);
    if (!stopBit) begin
      expFrameErr++;
    end else if (!bus.m_ready && expQ.size() > 0) begin
      expOverrun++;
    end else begin
      expQ.push_back(data);
    end
    sendFrame(data, stopBit);
  endtask

  // Monitor: pops an expected byte on every handshake and checks that a
  // stalled byte never changes.
  always @(negedge sysclk) begin
    if (!rst_n) begin
      prevHold = 1'b0;
    end else begin
      if (frame_err) nFrameErr++;
      if (overrun) nOverrun++;
      if (prevHold) checkOutput("hold_stable", 32'(bus.m_data), 32'(prevData));
      if (bus.m_valid && bus.m_ready) begin
        if (expQ.size() == 0) begin
          nVectors++;
          nMis++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", bus.m_data);
        end else begin
          checkOutput("byte", 32'(bus.m_data), 32'(expQ.pop_front()));
        end
      end
      prevHold = bus.m_valid && !bus.m_ready;
      prevData = bus.m_data;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_m_valid"}, 32'(bus.m_valid), 0);
    checkOutput({tag, "_m_data"}, 32'(bus.m_data), 0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_pending"}, 32'(expQ.size()), 0);
    checkOutput({tag, "_frame_err_cnt"}, 32'(nFrameErr), 32'(expFrameErr));
    checkOutput({tag, "_overrun_cnt"}, 32'(nOverrun), 32'(expOverrun));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors", nVectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic got;
    logic sawBusy;
    logic busyDone;

    bus.m_ready = 1'b1;
    idle(3);
    #1 checkResetOutputs("reset");
    rst_n = 1'b1;
    idle(4);

    // Single byte with latency check.
    $display("[TB] single byte 0xA5");
    lat = 0;
    got = 1'b0;
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge sysclk);
          if (bus.m_valid) begin
            lat = cyc - startCyc;
            got = 1'b1;
            break;
          end
        end
      end
    join
    checkOutput("a5_valid_seen", 32'(got), 1);
    checkOutput("a5_latency_in_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 1);
    idle(CPB);
    checkCounts("a5");

    // Short low glitch on an idle line must be rejected silently.
    $display("[TB] start glitch");
    idle(1);
    #1 uart_txd_in = 1'b0;
    idle(5);
    #1 uart_txd_in = 1'b1;
    sawBusy = 1'b0;
    busyDone = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sysclk);
      if (busy) sawBusy = 1'b1;
      if (sawBusy && !busy) begin
        busyDone = 1'b1;
        break;
      end
    end
    checkOutput("glitch_busy_rose", 32'(sawBusy), 1);
    checkOutput("glitch_busy_fell", 32'(busyDone), 1);
    idle(CPB);
    checkCounts("glitch");

    // Bad stop bit, then a good frame.
    $display("[TB] framing error then 0x3C");
    idle(1);
    applyStimulus(8'h5A, 1'b0);
    idle(2 * CPB);
    applyStimulus(8'h3C, 1'b1);
    idle(2 * CPB);
    checkCounts("framing");

    // Stalled consumer: second byte overruns, first byte is kept.
    $display("[TB] overrun with m_ready low");
    bus.m_ready = 1'b0;
    idle(1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    idle(2 * CPB);
    #1;
    checkOutput("ovr_m_valid_held", 32'(bus.m_valid), 1);
    checkOutput("ovr_m_data_held", 32'(bus.m_data), 32'h11);
    checkOutput("ovr_overrun_cnt", 32'(nOverrun), 32'(expOverrun));
    bus.m_ready = 1'b1;
    idle(3);
    #1;
    checkOutput("ovr_drained_m_valid", 32'(bus.m_valid), 0);
    checkCounts("overrun");

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x81.
    $display("[TB] reset mid-frame");
    idle(1);
    fork
      sendFrame(8'hFF, 1'b1);
      begin
        idle(CPB * 5 + CPB / 2);
        #1 rst_n = 1'b0;
        idle(2);
        #1 checkResetOutputs("midreset");
        idle(8);
        #1 rst_n = 1'b1;
      end
    join
    idle(2 * CPB);
    applyStimulus(8'h81, 1'b1);
    idle(2 * CPB);
    checkCounts("midreset");

    // Back-to-back random bytes with no idle gap.
    $display("[TB] 31 back-to-back random bytes");
    idle(1);
    for (int i = 0; i < 31; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    end
    idle(3 * CPB);
    checkCounts("burst");
    checkOutput("final_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMis);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver front end inside UART_Wrapper. Converts the serial line on uart_txd_in into bytes.
- Samples 8N1 frames at mid-bit using a fixed clock-per-bit divider.
- Delivers each byte through a one-entry valid/ready holding register to the downstream byte consumer.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 1302, sysclk cycles per UART bit (12.5 MHz / 9600 baud); legal range is >= 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- sysclk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- uart_txd_in  in  1  serial line; idle high; asynchronous to sysclk.
- m_data  out  DATA_BITS  received byte; stable while m_valid=1.
- m_valid  out  1  a byte is held and available.
- m_ready  in  1  consumer accepts the byte when m_valid && m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a byte completed while the holding register was full and not draining; the new byte is dropped.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values (async): m_data=0, m_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchronizer flops=1, bit counter=0, clock counter=0.
- Input path: 2-FF synchronizer on uart_txd_in. All decisions use the synchronized signal rxs, which adds 2 cycles of latency.
- Clock counter width is $clog2(CLKS_PER_BIT). Bit counter width is $clog2(DATA_BITS+1).
- State machine:
  - IDLE: rxs==0 -> START, clock counter cleared.
  - START: at count CLKS_PER_BIT/2-1, sample rxs. If 0 -> DATA with counters cleared. If 1 -> IDLE (glitch rejected, no pulse).
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit[bit_cnt] (LSB first). After the DATA_BITS-th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs. If 1 -> deliver the byte and go to IDLE. If 0 -> pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then -> IDLE. This prevents a break condition or stuck-low line from retriggering.
- Delivery happens in the cycle after the stop sample:
  - m_valid==0, or m_valid && m_ready in that same cycle: load m_data and keep or set m_valid=1. Simultaneous drain and load means the new byte wins.
  - m_valid && !m_ready: m_data unchanged, overrun pulses for 1 cycle, new byte dropped.
- Handshake: m_valid clears the cycle after m_valid && m_ready, unless a load happens in that same cycle. m_data never changes while m_valid=1 && !m_ready.
- Latency: the falling start edge reaches the pin; m_valid rises 2 + (CLKS_PER_BIT/2) + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles later (±1 for edge phase).
- Back-to-back frames: the new start bit is detected in IDLE immediately after the stop sample. There is no requirement for extra idle time.
- Reset mid-frame: all state is abandoned and the partial byte is lost. After release, the receiver waits in IDLE for the next falling edge. A line that is already low at release is treated as a start bit.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - default CLKS_PER_BIT = 1302 and DATA_BITS = 8, for reuse by uart_tx and the benches.
- One sub-module: sync_2ff (parameterised reset value, here 1). It is reused for every asynchronous input in the wrapper.

Test Plan:
- Send 0xA5, 8N1, 1302 clk/bit, m_ready=1 -> one m_valid pulse with m_data=0xA5, about 12370 cycles after the start edge; no frame_err or overrun.
- 300-cycle low glitch on an idle line -> no m_valid, no frame_err, busy returns to 0 within 660 cycles.
- Frame 0x5A with the stop bit driven low, then line high, then 0x3C -> one frame_err pulse, no byte for 0x5A, then m_data=0x3C valid.
- m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11 with m_valid=1, one overrun pulse at the end of 0x22; raising m_ready drains 0x11, then m_valid=0.
- Assert rst_n=0 in the middle of bit 4 of 0xFF, release it, send 0x81 -> all outputs are 0 during reset, and the only byte delivered is 0x81.
- 31 back-to-back bytes from test_input.mem with m_ready=1 -> 31 bytes delivered in order, equal to the memory contents, with zero error pulses.
